pipe_stage_reg: RTL and testbench

Generic, parametrised pipeline stage register. It is the successor to the fixed-field inter-stage latches (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Carries an arbitrary packed payload between stages using a valid/ready handshake.
- Supports data-hazard bubbles and control-hazard flushes, with a NOP payload emitted whenever the stage is empty.
- Optional 2-entry skid buffer registers the ready path.
- Saturating bubble and flush counters feed the performance monitor.

---
 rtl/pipe_stage_reg.sv | 111 +++++++++++
 tb/tb_pipe_stage_reg.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with a valid/ready handshake, bubble/flush hazard handling,
// an optional 2-entry skid buffer and saturating bubble/flush performance counters.
module pipe_stage_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter int               SKID      = 1,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             bubble,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // ONE doubles as FULL when SKID=0; TWO is only reachable with the skid entry.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] bubble_cnt_q, flush_cnt_q;
    logic             accept, drain;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = out_valid ? main_q : NOP_VALUE;
    assign drain     = out_valid & out_ready;
    assign accept    = in_valid & in_ready & ~bubble & ~flush;

    generate
        if (SKID != 0) begin : g_skid
            // Depends on registered state only, so out_ready never reaches in_ready.
            assign in_ready = (state_q != TWO);
        end else begin : g_noskid
            assign in_ready = ~out_valid | out_ready;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && (drain || SKID == 0)) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = TWO;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Flush takes precedence: a flush&bubble cycle counts as a flush only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (flush && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 1'b1;
            if (bubble && !flush && bubble_cnt_q != '1)
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a skid-buffered stage driven from a vector table, plus hand sequences for
// async reset, counter saturation/priority and the combinational ready of a SKID=0 stage.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst, flush, bubble, in_valid, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [15:0] bubble_cnt, flush_cnt;
    logic        in_ready2, out_valid2;
    logic [31:0] out_data2;
    logic [1:0]  bubble_cnt2, flush_cnt2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .NOP_VALUE(32'h13), .SKID(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bubble(bubble),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_reg #(.WIDTH(32), .NOP_VALUE(32'h13), .SKID(0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .bubble(bubble),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .bubble_cnt(bubble_cnt2), .flush_cnt(flush_cnt2)
    );

    typedef struct {
        int          rst, fl, bb, iv;
        logic [31:0] d;
        int          ordy;
        int          ov;
        logic [31:0] od;
        int          ir, bc, fc;
    } vec_t;

    vec_t v[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input int r, input int f, input int b, input int iv,
                         input logic [31:0] d, input int o);
        rst       = r[0];
        flush     = f[0];
        bubble    = b[0];
        in_valid  = iv[0];
        in_data   = d;
        out_ready = o[0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst fl bb iv data ordy | ov data ir bc fc  (expected after the edge)
        v[0]  = '{1,0,0,1,32'hDEADBEEF,1, 0,32'h13,1,0,0};
        v[1]  = '{0,0,0,1,32'h1,1,        1,32'h1, 1,0,0};
        v[2]  = '{0,0,0,1,32'h2,1,        1,32'h2, 1,0,0};
        v[3]  = '{0,0,0,1,32'h3,1,        1,32'h3, 1,0,0};
        v[4]  = '{0,0,0,0,32'h0,1,        0,32'h13,1,0,0};
        v[5]  = '{0,0,0,1,32'hA,0,        1,32'hA, 1,0,0};
        v[6]  = '{0,0,0,1,32'hB,0,        1,32'hA, 0,0,0};
        v[7]  = '{0,0,0,1,32'hC,0,        1,32'hA, 0,0,0};
        v[8]  = '{0,0,0,0,32'h0,1,        1,32'hB, 1,0,0};
        v[9]  = '{0,0,0,0,32'h0,1,        0,32'h13,1,0,0};
        v[10] = '{0,0,0,1,32'h7,0,        1,32'h7, 1,0,0};
        v[11] = '{0,0,1,1,32'h55,0,       1,32'h7, 1,1,0};
        v[12] = '{0,0,1,1,32'h55,1,       0,32'h13,1,2,0};
        v[13] = '{0,0,1,1,32'h55,1,       0,32'h13,1,3,0};
        v[14] = '{0,0,0,1,32'h55,1,       1,32'h55,1,3,0};
        v[15] = '{0,0,0,0,32'h0,1,        0,32'h13,1,3,0};
        v[16] = '{0,0,0,1,32'hA,0,        1,32'hA, 1,3,0};
        v[17] = '{0,0,0,1,32'hB,0,        1,32'hA, 0,3,0};
        v[18] = '{0,1,0,1,32'hC,0,        0,32'h13,1,3,1};
        v[19] = '{0,0,0,0,32'h0,0,        0,32'h13,1,3,1};
        v[20] = '{0,0,0,1,32'h9,0,        1,32'h9, 1,3,1};
        v[21] = '{0,1,1,1,32'h8,1,        0,32'h13,1,3,2};
        v[22] = '{0,0,0,1,32'h8,1,        1,32'h8, 1,3,2};
        v[23] = '{0,0,0,0,32'h0,1,        0,32'h13,1,3,2};

        drive(1, 0, 0, 1, 32'hDEADBEEF, 1);
        #1;
        chk("async rst out_data", out_data, 32'h13);
        chk("async rst out_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 24; i++) begin
            drive(v[i].rst, v[i].fl, v[i].bb, v[i].iv, v[i].d, v[i].ordy);
            step();
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(v[i].ov));
            chk($sformatf("v%0d out_data", i), out_data, v[i].od);
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(v[i].ir));
            chk($sformatf("v%0d bubble_cnt", i), 32'(bubble_cnt), 32'(v[i].bc));
            chk($sformatf("v%0d flush_cnt", i), 32'(flush_cnt), 32'(v[i].fc));
        end

        // Reset mid-transfer acts without a clock edge.
        drive(0, 0, 0, 1, 32'h77, 0);
        step();
        chk("pre-rst out_data", out_data, 32'h77);
        rst = 1'b1;
        #1;
        chk("mid rst out_valid", 32'(out_valid), 32'd0);
        chk("mid rst out_data", out_data, 32'h13);
        chk("mid rst flush_cnt", 32'(flush_cnt), 32'd0);
        chk("mid rst bubble_cnt", 32'(bubble_cnt), 32'd0);
        step();

        // Five flush&bubble cycles: flush wins, 2-bit counter saturates at 3.
        drive(0, 1, 1, 1, 32'h44, 1);
        for (int k = 0; k < 5; k++) step();
        chk("sat flush_cnt2", 32'(flush_cnt2), 32'd3);
        chk("sat bubble_cnt2", 32'(bubble_cnt2), 32'd0);
        chk("sat flush_cnt", 32'(flush_cnt), 32'd5);
        chk("sat bubble_cnt", 32'(bubble_cnt), 32'd0);
        chk("sat out_valid", 32'(out_valid), 32'd0);

        // SKID=0: in_ready follows out_ready combinationally when full.
        drive(0, 0, 0, 1, 32'h21, 0);
        step();
        chk("s0 out_data", out_data2, 32'h21);
        chk("s0 in_ready full", 32'(in_ready2), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("s0 in_ready comb", 32'(in_ready2), 32'd1);
        in_data = 32'h22;
        step();
        chk("s0 accept+drain", out_data2, 32'h22);
        chk("s1 accept+drain", out_data, 32'h22);
        in_valid = 1'b0;
        step();
        chk("s0 empty valid", 32'(out_valid2), 32'd0);
        chk("s0 empty nop", out_data2, 32'h13);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
